// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared constants, state type and round-robin search for adder_arbiter
package adder_arb_pkg;

    localparam int W        = 6;
    localparam int NREQ_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Returns {found, index}; the search starts at ptr and wraps modulo n (n <= 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] valid, input int ptr, input int n);
        logic [3:0] r;
        int         idx;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            idx = (ptr + i) % n;
            if ((i < n) && !r[3] && valid[3'(idx)]) begin
                r = {1'b1, 3'(idx)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - requester and response bundle between operand sources and adder_arbiter
interface adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
);
    import adder_arb_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_ov;
    logic [ID_W-1:0]   rsp_id;
    logic [CNT_W-1:0]  done_cnt;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_ov, rsp_id, done_cnt
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_ov, rsp_id, done_cnt
    );

endinterface

// File: rtl/adder_arbiter_adder.sv
// rtl/adder_arbiter_adder.sv - 6-bit gate-level prefix adder with explicit supply pins
module adder (
    input  wire x0, x1, x2, x3, x4, x5,
    input  wire y0, y1, y2, y3, y4, y5,
    input  wire gnd,
    input  wire vdd,
    output wire s0, s1, s2, s3, s4, s5,
    output wire ov
);
    wire p0, p1, p2, p3, p4, p5;
    wire g0, g1, g2, g3, g4, g5;
    wire c1, c2, c3, c4, c5;
    wire g32, p32, g54, p54;

    assign p0 = x0 ^ y0;
    assign p1 = x1 ^ y1;
    assign p2 = x2 ^ y2;
    assign p3 = x3 ^ y3;
    assign p4 = x4 ^ y4;
    assign p5 = x5 ^ y5;
    assign g0 = x0 & y0;
    assign g1 = x1 & y1;
    assign g2 = x2 & y2;
    assign g3 = x3 & y3;
    assign g4 = x4 & y4;
    assign g5 = x5 & y5;

    // Sklansky-style prefix tree; gnd is the carry-in of bit 0.
    assign c1  = g0 | (p0 & gnd);
    assign c2  = g1 | (p1 & c1);
    assign g32 = g3 | (p3 & g2);
    assign p32 = p3 & p2;
    assign c3  = g2 | (p2 & c2);
    assign c4  = g32 | (p32 & c2);
    assign g54 = g5 | (p5 & g4);
    assign p54 = p5 & p4;
    assign c5  = g4 | (p4 & c4);
    assign ov  = (g54 | (p54 & c4)) & vdd;

    assign s0 = (p0 ^ gnd) & vdd;
    assign s1 = (p1 ^ c1) & vdd;
    assign s2 = (p2 ^ c2) & vdd;
    assign s3 = (p3 ^ c3) & vdd;
    assign s4 = (p4 ^ c4) & vdd;
    assign s5 = (p5 ^ c5) & vdd;

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder, with a one-deep response buffer
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int ID_W  = id_w(NREQ),
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);
    supply0 gnd_net;
    supply1 vdd_net;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  gidx;
    logic [3:0]       pick;
    logic             consume, can_accept, grant;
    logic [W-1:0]     ax, ay, s;
    logic             ov;
    logic [W-1:0]     sum_q;
    logic             ov_q;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] cnt_q;

    assign consume    = (state_q == FULL) & bus.rsp_ready;
    assign can_accept = (state_q == EMPTY) | consume;
    assign pick       = rr_pick(8'(bus.req_valid), int'(ptr_q), NREQ);
    assign gidx       = ID_W'(pick[2:0]);
    // rst gates the grant so no requester sees ready while reset is held.
    assign grant      = ~rst & can_accept & pick[3];

    assign ax = bus.req_x[int'(gidx)*W +: W];
    assign ay = bus.req_y[int'(gidx)*W +: W];

    adder u_adder (
        .x0(ax[0]), .x1(ax[1]), .x2(ax[2]), .x3(ax[3]), .x4(ax[4]), .x5(ax[5]),
        .y0(ay[0]), .y1(ay[1]), .y2(ay[2]), .y3(ay[3]), .y4(ay[4]), .y5(ay[5]),
        .gnd(gnd_net), .vdd(vdd_net),
        .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .s5(s[5]),
        .ov(ov)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (consume && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[gidx] = 1'b1;
        end
        bus.rsp_valid = (state_q == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            sum_q <= '0;
            ov_q  <= 1'b0;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (grant) begin
                ptr_q <= ID_W'((int'(gidx) + 1) % NREQ);
                sum_q <= s;
                ov_q  <= ov;
                id_q  <= gidx;
            end
            if (consume) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.rsp_sum  = sum_q;
    assign bus.rsp_ov   = ov_q;
    assign bus.rsp_id   = id_q;
    assign bus.done_cnt = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [1:0] id;
        logic [5:0] sum;
        logic       ov;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    adder_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0] tx [NREQ];
    logic [5:0] ty [NREQ];
    rsp_t       sb[$];
    int         id_log[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         consumed = 0;
    int         exp_ids [6] = '{0, 1, 2, 3, 0, 1};
    logic       hit;

    always_comb begin
        bus.req_x = '0;
        bus.req_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*W +: W] = tx[i];
            bus.req_y[i*W +: W] = ty[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            rsp_t       e;
            logic [6:0] t;
            check("done_cnt", 32'(bus.done_cnt), 32'(consumed % 65536));
            check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
                    check("rsp_ov", 32'(bus.rsp_ov), 32'(e.ov));
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                end
                id_log.push_back(int'(bus.rsp_id));
                consumed++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    t = {1'b0, tx[i]} + {1'b0, ty[i]};
                    sb.push_back('{id: 2'(i), sum: t[5:0], ov: t[6]});
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        sb.delete();
        id_log.delete();
        consumed = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tx[i] = '0;
            ty[i] = '0;
        end
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #11;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check("reset_rsp_ov", 32'(bus.rsp_ov), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_done_cnt", 32'(bus.done_cnt), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // Single op on requester 0.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        tx[0] = 6'd5; ty[0] = 6'd7;
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_sum", 32'(bus.rsp_sum), 32'd12);
        check("t1_ov", 32'(bus.rsp_ov), 32'd0);
        check("t1_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk); #1;
        check("t1_done", 32'(bus.done_cnt), 32'd1);

        // Carry-out cases on requester 2, back to back.
        tx[2] = 6'd63; ty[2] = 6'd1;
        bus.req_valid = 4'b0100;
        @(posedge clk); #1;
        check("t2a_sum", 32'(bus.rsp_sum), 32'd0);
        check("t2a_ov", 32'(bus.rsp_ov), 32'd1);
        check("t2a_id", 32'(bus.rsp_id), 32'd2);
        tx[2] = 6'd40; ty[2] = 6'd40;
        @(posedge clk); #1;
        check("t2b_sum", 32'(bus.rsp_sum), 32'd16);
        check("t2b_ov", 32'(bus.rsp_ov), 32'd1);
        bus.req_valid = '0;
        @(posedge clk); #1;

        // Backpressure on requester 1.
        bus.rsp_ready = 1'b0;
        tx[1] = 6'd10; ty[1] = 6'd20;
        bus.req_valid = 4'b0010;
        @(posedge clk); #1;
        check("bp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_sum", 32'(bus.rsp_sum), 32'd30);
            check("bp_hold_id", 32'(bus.rsp_id), 32'd1);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        tx[1] = 6'd1; ty[1] = 6'd2;
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_same_cycle_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1;
        check("bp_next_sum", 32'(bus.rsp_sum), 32'd3);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        // Reset while a result is buffered; ptr would otherwise favour requester 3.
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        do_reset();
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // All requesters valid: strict rotation.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        repeat (6) begin
            for (int i = 0; i < NREQ; i++) begin
                tx[i] = 6'($urandom_range(0, 63));
                ty[i] = 6'($urandom_range(0, 63));
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rr_count", 32'(id_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("rr_id", (k < id_log.size()) ? 32'(id_log[k]) : 32'hFFFF_FFFF, 32'(exp_ids[k]));
        end
        check("rr_done", 32'(bus.done_cnt), 32'd6);

        // Counter wrap through continuous single-requester traffic.
        do_reset();
        tx[0] = 6'd33; ty[0] = 6'd31;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        hit = 1'b0;
        for (int c = 0; c < 70000 && !hit; c++) begin
            @(posedge clk); #2;
            if (consumed == 65535) begin
                check("cnt_max", 32'(bus.done_cnt), 32'h0000_FFFF);
                hit = 1'b1;
            end
        end
        if (!hit) check("cnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        check("cnt_wrap_consumed", 32'(consumed), 32'd65536);
        check("cnt_wrap", 32'(bus.done_cnt), 32'd0);
        bus.req_valid = '0;

        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) hit = 1'b1;
        end
        if (!hit) check("drain_timeout", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
